btn_press_detector: RTL and testbench
=====================================

// Module: btn_press_detector
// PURPOSE
//   Front-end button conditioner. Sits upstream of the LED speed/mode counters and drives their increment enables.
//   Synchronises raw push-buttons, then debounces them on a slow sample tick. Per button it emits: debounced level,
//   one-cycle press pulse, one-cycle long-press pulse, and periodic auto-repeat pulses while the button stays held.
// PARAMETERS
//   WIDTH     1       number of independent buttons
//   SMPL_DIV  125000  CLK cycles per sample tick (1 ms at 125 MHz); >= 2
//   DB_CNT    16      consecutive equal samples needed to accept a press or a release; >= 1
//   LONG_CNT  500     held samples after the accepted press before BTNLONG fires; >= 1
//   REP_CNT   100     held samples between successive BTNREP pulses once long-press is reached; >= 1
// PORTS
//   CLK      in   1      system clock, all logic on posedge
//   RST      in   1      synchronous reset, active-high
//   BTNIN    in   WIDTH  raw asynchronous button inputs, 1 = pressed
//   BTNLVL   out  WIDTH  debounced button level
//   BTNOUT   out  WIDTH  1-cycle pulse on each accepted press
//   BTNLONG  out  WIDTH  1-cycle pulse when a hold reaches LONG_CNT
//   BTNREP   out  WIDTH  1-cycle pulse every REP_CNT samples while in long-hold
// BEHAVIOUR
//   - Reset: synchronous. Prescaler, all counters, FSMs (IDLE) and all outputs are 0. Synchroniser flops are also
//     cleared to 0. RST asserted mid-operation aborts any hold: no pulses fire in the cycle after RST.
//   - Sync: 2-flop synchroniser per bit. Adds 2 cycles of latency before the FSM can see an input.
//   - Tick: one shared prescaler counts 0..SMPL_DIV-1 and wraps. tick=1 in the cycle where count==SMPL_DIV-1.
//     The FSMs and counters advance only on tick cycles.
//   - Per-button FSM (independent per bit). s = synchronised sample. dbc = debounce counter. hc = hold counter.
//     IDLE:     s=1 -> PRESS_CHK with dbc=1 (if DB_CNT==1, accept immediately, as below).
//     PRESS_CHK: s=1 -> dbc++. When dbc reaches DB_CNT: go to HELD, set BTNLVL=1, pulse BTNOUT, clear hc.
//                s=0 -> back to IDLE, dbc=0.
//     HELD:     s=1 -> hc++. When hc reaches LONG_CNT: go to LONG, pulse BTNLONG, clear hc.
//               s=0 -> REL_CHK with dbc=1, remember return state = HELD.
//     LONG:     s=1 -> hc++. When hc reaches REP_CNT: pulse BTNREP, clear hc, stay in LONG.
//               s=0 -> REL_CHK with dbc=1, remember return state = LONG.
//     REL_CHK:  s=0 -> dbc++. When dbc reaches DB_CNT: go to IDLE, set BTNLVL=0, clear hc.
//               s=1 -> go back to the remembered state. hc is frozen during REL_CHK and resumes, it is not cleared.
//               No pulse fires on the return.
//   - Outputs are registered. A pulse is high exactly in the cycle after the qualifying tick. Pulses never last
//     longer than 1 cycle and never fire on non-tick cycles. BTNLVL changes in the same cycle as the BTNOUT pulse
//     (press) or one cycle after the final release tick (release).
//   - Counter widths are $clog2(param+1). Counters saturate logically because they are cleared at their thresholds,
//     so they never wrap.
//   - Input changes between ticks are ignored; only the value sampled on a tick cycle matters.
//   - Buttons share only the prescaler. Simultaneous events on several bits are all reported in the same cycle.
// TESTING (bench params: SMPL_DIV=4, DB_CNT=3, LONG_CNT=8, REP_CNT=2, WIDTH=2)
//   1. After reset, hold BTNIN=0 for 100 cycles -> all outputs stay 0. Prescaler tick occurs every 4 cycles.
//   2. Clean press on bit0, held for 20 ticks -> exactly 1 BTNOUT[0] pulse, ~3 ticks + 2 cycles after the edge.
//      BTNLVL[0]=1 from that cycle. Exactly 1 BTNLONG[0] pulse 8 ticks after BTNOUT. BTNREP[0] pulses at +2 and
//      +4 ticks after BTNLONG, and so on.
//   3. Bounce: toggle bit0 every 5 cycles for 60 cycles, then hold 1 -> no pulse during bounce. Exactly 1 BTNOUT
//      once 3 stable ticks are seen. Bit1 remains 0.
//   4. Release glitch: in LONG state, drop bit0 for 1 tick, then restore -> BTNLVL stays 1, no extra BTNOUT/BTNLONG.
//      BTNREP cadence resumes from the frozen hc.
//   5. Release: hold bit0 at 0 for 3 ticks -> BTNLVL[0] falls. A new press afterwards yields a fresh BTNOUT and
//      restarts the LONG count.
//   6. Both bits pressed on the same cycle -> BTNOUT=2'b11 in one cycle. Assert RST during HELD -> outputs 0 next
//      cycle. Releasing RST with buttons still held -> debounce restarts from IDLE.

Source files
------------

// File: rtl/btn_press_detector.sv
// Push-button conditioner: 2-flop synchroniser, shared sample prescaler and a per-button
// debounce / long-press / auto-repeat FSM with registered level and pulse outputs.
module btn_press_detector #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned SMPL_DIV = 125000,
    parameter int unsigned DB_CNT   = 16,
    parameter int unsigned LONG_CNT = 500,
    parameter int unsigned REP_CNT  = 100
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] BTNIN,
    output logic [WIDTH-1:0] BTNLVL,
    output logic [WIDTH-1:0] BTNOUT,
    output logic [WIDTH-1:0] BTNLONG,
    output logic [WIDTH-1:0] BTNREP
);

    localparam int unsigned PW    = $clog2(SMPL_DIV);
    localparam int unsigned DBW   = $clog2(DB_CNT + 1);
    localparam int unsigned HCMAX = (LONG_CNT > REP_CNT) ? LONG_CNT : REP_CNT;
    localparam int unsigned HCW   = $clog2(HCMAX + 1);

    localparam logic [PW-1:0]  PS_LAST   = PW'(SMPL_DIV - 1);
    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CNT - 1);
    localparam logic [HCW-1:0] LONG_LAST = HCW'(LONG_CNT - 1);
    localparam logic [HCW-1:0] REP_LAST  = HCW'(REP_CNT - 1);

    typedef enum logic [2:0] {StIdle, StPressChk, StHeld, StLong, StRelChk} state_e;

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [PW-1:0]    ps_q;
    logic             tick;

    assign tick = (ps_q == PS_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
            ps_q    <= '0;
        end else begin
            sync1_q <= BTNIN;
            sync2_q <= sync1_q;
            ps_q    <= tick ? '0 : ps_q + PW'(1);
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_btn
        state_e         state_q, state_d;
        logic [DBW-1:0] dbc_q, dbc_d;
        logic [HCW-1:0] hc_q, hc_d;
        logic           ret_long_q, ret_long_d;
        logic           lvl_q, lvl_d, out_q, out_d, long_q, long_d, rep_q, rep_d;
        logic           s, db_done;

        assign s       = sync2_q[i];
        // dbc holds samples seen so far, so this sample completes the run when dbc == DB_CNT-1
        assign db_done = (dbc_q == DB_LAST);

        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q    <= StIdle;
                dbc_q      <= '0;
                hc_q       <= '0;
                ret_long_q <= 1'b0;
                lvl_q      <= 1'b0;
                out_q      <= 1'b0;
                long_q     <= 1'b0;
                rep_q      <= 1'b0;
            end else begin
                state_q    <= state_d;
                dbc_q      <= dbc_d;
                hc_q       <= hc_d;
                ret_long_q <= ret_long_d;
                lvl_q      <= lvl_d;
                out_q      <= out_d;
                long_q     <= long_d;
                rep_q      <= rep_d;
            end
        end

        always_comb begin
            state_d    = state_q;
            dbc_d      = dbc_q;
            hc_d       = hc_q;
            ret_long_d = ret_long_q;
            if (tick) begin
                case (state_q)
                    StIdle, StPressChk: begin
                        if (!s) begin
                            state_d = StIdle;
                            dbc_d   = '0;
                        end else if (db_done) begin
                            state_d = StHeld;
                            dbc_d   = '0;
                            hc_d    = '0;
                        end else begin
                            state_d = StPressChk;
                            dbc_d   = dbc_q + DBW'(1);
                        end
                    end
                    StHeld, StLong: begin
                        if (s) begin
                            if (state_q == StHeld && hc_q == LONG_LAST) begin
                                state_d = StLong;
                                hc_d    = '0;
                            end else if (state_q == StLong && hc_q == REP_LAST) begin
                                hc_d = '0;
                            end else begin
                                hc_d = hc_q + HCW'(1);
                            end
                        end else if (db_done) begin
                            state_d = StIdle;
                            hc_d    = '0;
                        end else begin
                            state_d    = StRelChk;
                            dbc_d      = DBW'(1);
                            ret_long_d = (state_q == StLong);
                        end
                    end
                    StRelChk: begin
                        if (s) begin
                            // hc stays frozen so the hold cadence resumes where it stopped
                            state_d = ret_long_q ? StLong : StHeld;
                            dbc_d   = '0;
                        end else if (db_done) begin
                            state_d = StIdle;
                            dbc_d   = '0;
                            hc_d    = '0;
                        end else begin
                            dbc_d = dbc_q + DBW'(1);
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end

        always_comb begin
            lvl_d  = (state_d == StHeld) || (state_d == StLong) || (state_d == StRelChk);
            out_d  = 1'b0;
            long_d = 1'b0;
            rep_d  = 1'b0;
            if (tick && s) begin
                case (state_q)
                    StIdle, StPressChk: out_d  = db_done;
                    StHeld:             long_d = (hc_q == LONG_LAST);
                    StLong:             rep_d  = (hc_q == REP_LAST);
                    default: ;
                endcase
            end
        end

        assign BTNLVL[i]  = lvl_q;
        assign BTNOUT[i]  = out_q;
        assign BTNLONG[i] = long_q;
        assign BTNREP[i]  = rep_q;
    end

endmodule

// File: tb/tb_btn_press_detector.sv
// Bench for btn_press_detector: directed scenarios plus random button activity, checked every
// cycle against a level/run-length reference model of the debounce and hold rules.
module tb_btn_press_detector;
    localparam int unsigned W        = 2;
    localparam int unsigned SMPL_DIV = 4;
    localparam int unsigned DB_CNT   = 3;
    localparam int unsigned LONG_CNT = 8;
    localparam int unsigned REP_CNT  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] btnin = '0;
    logic [W-1:0] btnlvl, btnout, btnlong, btnrep;

    always #5 clk = ~clk;

    btn_press_detector #(
        .WIDTH   (W),
        .SMPL_DIV(SMPL_DIV),
        .DB_CNT  (DB_CNT),
        .LONG_CNT(LONG_CNT),
        .REP_CNT (REP_CNT)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .BTNIN  (btnin),
        .BTNLVL (btnlvl),
        .BTNOUT (btnout),
        .BTNLONG(btnlong),
        .BTNREP (btnrep)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted level, length of the current run of samples disagreeing with it,
    // and ticks held since the last press/long/repeat event.
    int unsigned  cyc = 0;
    logic [W-1:0] m_s1 = '0, m_s2 = '0;
    logic [W-1:0] e_lvl = '0, e_out = '0, e_long = '0, e_rep = '0;
    int           run [W];
    int           hold[W];
    bit           lng [W];

    task automatic model_step();
        logic [W-1:0] s;
        bit           tick;
        if (rst) begin
            cyc = 0; m_s1 = '0; m_s2 = '0;
            e_lvl = '0; e_out = '0; e_long = '0; e_rep = '0;
            for (int i = 0; i < W; i++) begin run[i] = 0; hold[i] = 0; lng[i] = 0; end
            return;
        end
        tick = ((cyc % SMPL_DIV) == SMPL_DIV - 1);
        cyc++;
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = btnin;
        e_out = '0; e_long = '0; e_rep = '0;
        if (!tick) return;
        for (int i = 0; i < W; i++) begin
            if (!e_lvl[i]) begin
                run[i] = s[i] ? run[i] + 1 : 0;
                if (run[i] == DB_CNT) begin
                    e_lvl[i] = 1'b1; e_out[i] = 1'b1;
                    run[i] = 0; hold[i] = 0; lng[i] = 0;
                end
            end else if (!s[i]) begin
                run[i]++;
                if (run[i] == DB_CNT) begin e_lvl[i] = 1'b0; run[i] = 0; end
            end else if (run[i] > 0) begin
                run[i] = 0;
            end else begin
                hold[i]++;
                if (!lng[i] && hold[i] == LONG_CNT) begin
                    e_long[i] = 1'b1; lng[i] = 1; hold[i] = 0;
                end else if (lng[i] && hold[i] == REP_CNT) begin
                    e_rep[i] = 1'b1; hold[i] = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    bit check_en = 1'b0;
    int n_out[W], n_long[W], n_rep[W];
    int n_both = 0, n_lvl0_low = 0;

    initial begin
        for (int i = 0; i < W; i++) begin n_out[i] = 0; n_long[i] = 0; n_rep[i] = 0; end
        forever begin
            @(negedge clk);
            if (check_en) begin
                check_eq("lvl",  32'(btnlvl),  32'(e_lvl));
                check_eq("out",  32'(btnout),  32'(e_out));
                check_eq("long", 32'(btnlong), 32'(e_long));
                check_eq("rep",  32'(btnrep),  32'(e_rep));
                for (int i = 0; i < W; i++) begin
                    if (btnout[i])  n_out[i]++;
                    if (btnlong[i]) n_long[i]++;
                    if (btnrep[i])  n_rep[i]++;
                end
                if (btnout == 2'b11) n_both++;
                if (!btnlvl[0])      n_lvl0_low++;
            end
        end
    end

    task automatic drive(input logic [W-1:0] v, input int n);
        btnin = v;
        repeat (n) @(negedge clk);
    endtask

    int a_out0, a_out1, a_long0, a_rep0, a_lvl0, a_both;

    task automatic snap();
        a_out0 = n_out[0]; a_out1 = n_out[1]; a_long0 = n_long[0];
        a_rep0 = n_rep[0]; a_lvl0 = n_lvl0_low; a_both = n_both;
    endtask

    initial begin
        @(negedge clk);
        check_en = 1'b1;
        check_eq("reset_lvl", 32'(btnlvl), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle
        snap();
        drive(2'b00, 100);
        check_eq("idle_pulses", 32'(n_out[0] + n_out[1] + n_long[0] + n_rep[0] - a_out0 - a_out1
                                    - a_long0 - a_rep0), 32'd0);

        // Clean press held 20 ticks
        snap();
        drive(2'b01, 80);
        check_eq("press_out",  32'(n_out[0] - a_out0), 32'd1);
        check_eq("press_long", 32'(n_long[0] - a_long0), 32'd1);
        check_eq("press_rep_seen", 32'((n_rep[0] - a_rep0) >= 3), 32'd1);
        check_eq("press_lvl", 32'(btnlvl[0]), 32'd1);
        drive(2'b00, 40);
        check_eq("release_lvl", 32'(btnlvl[0]), 32'd0);

        // Bounce then stable hold
        snap();
        for (int k = 0; k < 12; k++) drive((k % 2 == 0) ? 2'b01 : 2'b00, 5);
        check_eq("bounce_out", 32'(n_out[0] - a_out0), 32'd0);
        drive(2'b01, 80);
        check_eq("bounce_then_out", 32'(n_out[0] - a_out0), 32'd1);
        check_eq("bounce_bit1", 32'(n_out[1] - a_out1), 32'd0);

        // One-tick release glitch while in long-hold
        snap();
        drive(2'b00, 4);
        drive(2'b01, 40);
        check_eq("glitch_out",  32'(n_out[0] - a_out0), 32'd0);
        check_eq("glitch_long", 32'(n_long[0] - a_long0), 32'd0);
        check_eq("glitch_lvl_low", 32'(n_lvl0_low - a_lvl0), 32'd0);
        check_eq("glitch_rep_seen", 32'((n_rep[0] - a_rep0) >= 3), 32'd1);

        // Release, then a fresh press restarts the long count
        drive(2'b00, 24);
        check_eq("rel_lvl", 32'(btnlvl[0]), 32'd0);
        snap();
        drive(2'b01, 60);
        check_eq("repress_out",  32'(n_out[0] - a_out0), 32'd1);
        check_eq("repress_long", 32'(n_long[0] - a_long0), 32'd1);
        drive(2'b00, 24);

        // Simultaneous press, reset while held, restart from idle
        snap();
        drive(2'b11, 30);
        check_eq("both_out", 32'(n_both - a_both), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_lvl", 32'(btnlvl), 32'd0);
        check_eq("rst_pulses", 32'({btnout, btnlong, btnrep}), 32'd0);
        snap();
        drive(2'b11, 40);
        check_eq("post_rst_out0", 32'(n_out[0] - a_out0), 32'd1);
        check_eq("post_rst_out1", 32'(n_out[1] - a_out1), 32'd1);
        check_eq("post_rst_lvl", 32'(btnlvl), 32'd3);

        // Random activity, occasional reset
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            drive(W'($urandom_range(0, 3)), int'($urandom_range(1, 60)));
        end
        drive(2'b00, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
